controlador_cruce: RTL
======================

Name: controlador_cruce

Overview:
Two-direction intersection scheduler. It shares the crossing between direction A and direction B, inserts an all-red clearance after every amber, and grants a pedestrian phase when one is requested. It is a Moore FSM with per-state timing derived from the system clock. It is the intersection-level controller above the single-light FSM, and its outputs drive the six vehicle LEDs and the walk LED directly.

Parameters:
FRECUENCIA_RELOJ, 100_000_000, clock cycles per second
TIEMPO_VERDE, 5, green duration in seconds, per direction
TIEMPO_AMARILLO, 1, amber duration in seconds
TIEMPO_TODO_ROJO, 1, all-red clearance in seconds
TIEMPO_PEATON, 4, pedestrian walk duration in seconds

Ports:
reloj  input  1  100 MHz system clock
reset  input  1  reset, synchronous, active-high
sol_peaton  input  1  pedestrian request; level or pulse, sampled every cycle
ack_peaton  output  1  one-cycle pulse when the pedestrian phase is entered
a_verde, a_amarillo, a_rojo  output  1 each  direction A lamps
b_verde, b_amarillo, b_rojo  output  1 each  direction B lamps
peaton_cruce  output  1  walk lamp
estado  output  3  current state code, for debug

Behaviour:
- States and codes: A_VERDE=0, A_AMARILLO=1, ROJO_AB=2, B_VERDE=3, B_AMARILLO=4, ROJO_BA=5, PEATON=6. Code 7 is reserved.
- Timing:
  - A prescaler counts 0..FRECUENCIA_RELOJ-1 and emits a tick on the terminal count.
  - A seconds counter increments on each tick.
  - Both counters clear on every state change, so a state lasting N seconds lasts exactly N*FRECUENCIA_RELOJ cycles.
  - Counters are 32 bits each.
- Transitions, taken on the cycle the seconds counter reaches the state's duration:
  - A_VERDE -> A_AMARILLO
  - A_AMARILLO -> ROJO_AB
  - B_VERDE -> B_AMARILLO
  - B_AMARILLO -> ROJO_BA
  - ROJO_AB -> PEATON if pendiente=1, else B_VERDE
  - ROJO_BA -> PEATON if pendiente=1, else A_VERDE
  - PEATON -> the green that would have followed the clearance it came from. A 1-bit register siguiente_b records this.
  - Code 7 -> ROJO_BA on the next cycle.
- Pedestrian request latch:
  - pendiente is set on any cycle with sol_peaton=1.
  - pendiente is cleared on the cycle PEATON is entered; ack_peaton=1 on that same cycle.
  - If sol_peaton=1 on the entry cycle, set wins and pendiente stays 1, so the request is served at the next clearance.
  - A request arriving during green or amber waits for the next all-red state. It never shortens green.
- Outputs (Moore, decoded from estado only):
  - Each direction shows exactly one lamp.
  - Direction A is red in every state except A_VERDE and A_AMARILLO; direction B likewise.
  - peaton_cruce=1 only in PEATON.
  - Any state outside the code list drives all vehicle reds and walk=0.
- Safety invariant: a_verde|a_amarillo and b_verde|b_amarillo are never both 1. peaton_cruce=1 implies all vehicle reds.
- Reset:
  - estado=A_VERDE, both counters 0, pendiente=0, siguiente_b=1.
  - Outputs: a_verde=1, b_rojo=1, all others 0, ack_peaton=0.
  - Reset asserted mid-phase, including PEATON, takes effect on the next edge and discards any pending request.

Optional Feature:
MODO_NOCTURNO_EN
- When defined:
  - Adds input modo_noche (1 bit) and state NOCHE=7.
  - With modo_noche=1, any state goes to NOCHE on the next cycle.
  - In NOCHE, a_amarillo and b_amarillo blink together: on for FRECUENCIA_RELOJ/2 cycles, off for FRECUENCIA_RELOJ/2 cycles, starting on. All other lamps are 0.
  - Requests still set pendiente, but no ack is issued.
  - When modo_noche falls, NOCHE -> ROJO_BA and normal rules resume.
- When undefined: no port, and code 7 behaves as an invalid state.

Test Plan:
Bench parameters for all scenarios: FRECUENCIA_RELOJ=4, VERDE=3, AMARILLO=1, TODO_ROJO=1, PEATON=2.
1. Release reset, no requests -> a_verde for 12 cycles, a_amarillo for 4, all-red for 4, b_verde for 12, b_amarillo for 4, all-red for 4, then a_verde again. The full period is 40 cycles.
2. Pulse sol_peaton for 1 cycle, 3 cycles into A_VERDE -> green is not shortened. After ROJO_AB, ack_peaton pulses once, peaton_cruce=1 for 8 cycles with all reds, then b_verde.
3. Hold sol_peaton high through an entire PEATON phase -> pendiente stays set and a second PEATON follows ROJO_BA, ahead of a_verde.
4. Assert reset for 1 cycle in mid B_AMARILLO with a request pending -> next cycle shows estado=0, a_verde=1, b_rojo=1. No PEATON phase occurs in the following cycle.
5. Check the safety invariant every cycle across 1000 cycles of random sol_peaton -> no violation.
6. With MODO_NOCTURNO_EN defined, raise modo_noche during B_VERDE:
   - Expected: NOCHE next cycle, ambers toggle every 2 cycles.
   - Then lower modo_noche -> ROJO_BA for 4 cycles, then a_verde.

Source files
------------

// File: rtl/controlador_cruce.sv
// Two-direction intersection scheduler with all-red clearance and a pedestrian phase.
// Defining MODO_NOCTURNO_EN adds the modo_noche input and the flashing-amber NOCHE state.
module controlador_cruce #(
  parameter int unsigned FRECUENCIA_RELOJ = 100_000_000,
  parameter int unsigned TIEMPO_VERDE     = 5,
  parameter int unsigned TIEMPO_AMARILLO  = 1,
  parameter int unsigned TIEMPO_TODO_ROJO = 1,
  parameter int unsigned TIEMPO_PEATON    = 4
) (
  input  logic       reloj,
  input  logic       reset,
  input  logic       sol_peaton,
`ifdef MODO_NOCTURNO_EN
  input  logic       modo_noche,
`endif
  output logic       ack_peaton,
  output logic       a_verde,
  output logic       a_amarillo,
  output logic       a_rojo,
  output logic       b_verde,
  output logic       b_amarillo,
  output logic       b_rojo,
  output logic       peaton_cruce,
  output logic [2:0] estado
);

`ifdef MODO_NOCTURNO_EN
  typedef enum logic [2:0] {
    StAVerde    = 3'd0,
    StAAmarillo = 3'd1,
    StRojoAB    = 3'd2,
    StBVerde    = 3'd3,
    StBAmarillo = 3'd4,
    StRojoBA    = 3'd5,
    StPeaton    = 3'd6,
    StNoche     = 3'd7
  } estado_t;
`else
  typedef enum logic [2:0] {
    StAVerde    = 3'd0,
    StAAmarillo = 3'd1,
    StRojoAB    = 3'd2,
    StBVerde    = 3'd3,
    StBAmarillo = 3'd4,
    StRojoBA    = 3'd5,
    StPeaton    = 3'd6
  } estado_t;
`endif

  localparam logic [31:0] PRE_MAX = 32'(FRECUENCIA_RELOJ - 1);

  estado_t     estado_q, estado_d;
  logic [31:0] pre_q, pre_d;
  logic [31:0] seg_q, seg_d;
  logic        pendiente_q, pendiente_d;
  logic        siguiente_b_q, siguiente_b_d;
  logic        tick, fin, cambio, entra_peaton;
`ifdef MODO_NOCTURNO_EN
  logic        parpadeo;
`endif

  assign estado = estado_q;

  function automatic logic [31:0] duracion(input estado_t e);
    case (e)
      StAVerde, StBVerde:       duracion = 32'(TIEMPO_VERDE);
      StAAmarillo, StBAmarillo: duracion = 32'(TIEMPO_AMARILLO);
      StRojoAB, StRojoBA:       duracion = 32'(TIEMPO_TODO_ROJO);
      StPeaton:                 duracion = 32'(TIEMPO_PEATON);
      default:                  duracion = 32'd0;
    endcase
  endfunction

  // A state of N seconds ends on the tick that would make the seconds count reach N,
  // giving exactly N*FRECUENCIA_RELOJ cycles.
  assign tick = (pre_q == PRE_MAX);
  assign fin  = tick && (seg_q == duracion(estado_q) - 32'd1);

  always_comb begin
    estado_d      = estado_q;
    siguiente_b_d = siguiente_b_q;
    case (estado_q)
      StAVerde:    if (fin) estado_d = StAAmarillo;
      StAAmarillo: if (fin) estado_d = StRojoAB;
      StBVerde:    if (fin) estado_d = StBAmarillo;
      StBAmarillo: if (fin) estado_d = StRojoBA;
      StRojoAB: begin
        if (fin) begin
          estado_d      = pendiente_q ? StPeaton : StBVerde;
          siguiente_b_d = 1'b1;
        end
      end
      StRojoBA: begin
        if (fin) begin
          estado_d      = pendiente_q ? StPeaton : StAVerde;
          siguiente_b_d = 1'b0;
        end
      end
      StPeaton:    if (fin) estado_d = siguiente_b_q ? StBVerde : StAVerde;
      // NOCHE after modo_noche falls, or an unreachable code: recover through a clearance.
      default:     estado_d = StRojoBA;
    endcase
`ifdef MODO_NOCTURNO_EN
    if (modo_noche) estado_d = StNoche;
`endif
  end

  assign cambio       = (estado_d != estado_q);
  assign entra_peaton = (estado_d == StPeaton) && (estado_q != StPeaton);
  assign pendiente_d  = sol_peaton | (pendiente_q & ~entra_peaton);

  always_comb begin
    if (cambio || tick) pre_d = 32'd0;
    else                pre_d = pre_q + 32'd1;
    if (cambio)         seg_d = 32'd0;
    else if (tick)      seg_d = seg_q + 32'd1;
    else                seg_d = seg_q;
  end

`ifdef MODO_NOCTURNO_EN
  // Ambers are lit during the first half of every prescaler period.
  assign parpadeo = (pre_d < 32'(FRECUENCIA_RELOJ / 2));
`endif

  always_ff @(posedge reloj) begin
    if (reset) begin
      estado_q      <= StAVerde;
      pre_q         <= 32'd0;
      seg_q         <= 32'd0;
      pendiente_q   <= 1'b0;
      siguiente_b_q <= 1'b1;
      ack_peaton    <= 1'b0;
      a_verde       <= 1'b1;
      a_amarillo    <= 1'b0;
      a_rojo        <= 1'b0;
      b_verde       <= 1'b0;
      b_amarillo    <= 1'b0;
      b_rojo        <= 1'b1;
      peaton_cruce  <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      pre_q         <= pre_d;
      seg_q         <= seg_d;
      pendiente_q   <= pendiente_d;
      siguiente_b_q <= siguiente_b_d;
      ack_peaton    <= entra_peaton;
      a_verde       <= 1'b0;
      a_amarillo    <= 1'b0;
      a_rojo        <= 1'b0;
      b_verde       <= 1'b0;
      b_amarillo    <= 1'b0;
      b_rojo        <= 1'b0;
      peaton_cruce  <= 1'b0;
      // Lamps are decoded from the next state so they line up with the estado register.
      case (estado_d)
        StAVerde: begin
          a_verde <= 1'b1;
          b_rojo  <= 1'b1;
        end
        StAAmarillo: begin
          a_amarillo <= 1'b1;
          b_rojo     <= 1'b1;
        end
        StBVerde: begin
          a_rojo  <= 1'b1;
          b_verde <= 1'b1;
        end
        StBAmarillo: begin
          a_rojo     <= 1'b1;
          b_amarillo <= 1'b1;
        end
        StPeaton: begin
          a_rojo       <= 1'b1;
          b_rojo       <= 1'b1;
          peaton_cruce <= 1'b1;
        end
`ifdef MODO_NOCTURNO_EN
        StNoche: begin
          a_amarillo <= parpadeo;
          b_amarillo <= parpadeo;
        end
`endif
        default: begin
          a_rojo <= 1'b1;
          b_rojo <= 1'b1;
        end
      endcase
    end
  end

  a_conflicto: assert property (@(posedge reloj) disable iff (reset)
    !((a_verde | a_amarillo) && (b_verde | b_amarillo)));
  a_peaton_rojos: assert property (@(posedge reloj) disable iff (reset)
    peaton_cruce |-> (a_rojo && b_rojo));

endmodule
